burst_mem_responder: RTL and testbench

BURST_MEM_RESPONDER -- requirements
Module: burst_mem_responder

---
 rtl/burst_mem_responder.sv | 121 ++++++++++++
 tb/tb_burst_mem_responder.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/burst_mem_responder.sv
// Line-oriented burst memory responder: a request sampled in IDLE is answered with
// four 64-bit beats after a fixed latency, reading from or writing into a LINES x 256-bit array.
module burst_mem_responder #(
    parameter int LINES   = 16,
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pmem_read,
    input  logic        pmem_write,
    input  logic [31:0] pmem_address,
    input  logic [63:0] pmem_wdata,
    output logic [63:0] pmem_rdata,
    output logic        pmem_resp,
    output logic        proto_err,
    output logic [1:0]  dbg_state_o
);

    localparam int IDX_W = $clog2(LINES);
    localparam int CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_BURST = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic               is_write_q;
    logic [CNT_W-1:0]   lat_cnt_q;
    logic [1:0]         beat_q;
    logic [63:0]        rdata_q;
    logic               resp_q;
    logic               err_q;
    logic [255:0]       mem_q [LINES];

    logic [IDX_W-1:0]   idx_d;
    logic [1:0]         beat_d;
    logic [255:0]       line_d;
    logic               unused_addr_bits;

    // Byte offset and the bits above the index only alias lines, so they are discarded.
    assign idx_d            = pmem_address[5 +: IDX_W];
    assign unused_addr_bits = ^{pmem_address[31:5+IDX_W], pmem_address[4:0]};
    assign beat_d           = beat_q + 2'd1;
    assign line_d           = mem_q[idx_q];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            is_write_q <= 1'b0;
            lat_cnt_q  <= '0;
            beat_q     <= 2'd0;
            rdata_q    <= 64'd0;
            resp_q     <= 1'b0;
            err_q      <= 1'b0;
            for (int i = 0; i < LINES; i++) begin
                mem_q[i] <= 256'd0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    resp_q  <= 1'b0;
                    rdata_q <= 64'd0;
                    if (pmem_read || pmem_write) begin
                        // A simultaneous read+write is served as a read; the write is lost.
                        idx_q      <= idx_d;
                        is_write_q <= pmem_write && !pmem_read;
                        lat_cnt_q  <= CNT_W'(LATENCY);
                        state_q    <= S_WAIT;
                        if (pmem_read && pmem_write) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (lat_cnt_q == '0) begin
                        state_q <= S_BURST;
                        beat_q  <= 2'd0;
                        resp_q  <= 1'b1;
                        rdata_q <= is_write_q ? 64'd0 : line_d[63:0];
                    end else begin
                        lat_cnt_q <= lat_cnt_q - CNT_W'(1);
                    end
                end
                S_BURST: begin
                    if (is_write_q) begin
                        mem_q[idx_q][{beat_q, 6'd0} +: 64] <= pmem_wdata;
                    end
                    if (beat_q == 2'd3) begin
                        state_q <= S_DONE;
                        beat_q  <= 2'd0;
                        resp_q  <= 1'b0;
                        rdata_q <= 64'd0;
                    end else begin
                        beat_q  <= beat_d;
                        resp_q  <= 1'b1;
                        rdata_q <= is_write_q ? 64'd0 : line_d[{beat_d, 6'd0} +: 64];
                    end
                end
                S_DONE: begin
                    resp_q  <= 1'b0;
                    rdata_q <= 64'd0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign pmem_rdata  = rdata_q;
    assign pmem_resp   = resp_q;
    assign proto_err   = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed + randomized bench for burst_mem_responder against a line/beat array model.
module tb_burst_mem_responder;

    localparam int LINES   = 16;
    localparam int LATENCY = 4;

    logic        clk;
    logic        reset_n;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    logic [63:0] pmem_wdata;
    logic [63:0] pmem_rdata;
    logic        pmem_resp;
    logic        proto_err;
    logic [1:0]  dbg_state;

    int pass_cnt;
    int total_cnt;

    logic [63:0] model_mem [LINES][4];
    logic        model_err;

    burst_mem_responder #(.LINES(LINES), .LATENCY(LATENCY)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .proto_err    (proto_err),
        .dbg_state_o  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_clear();
        for (int l = 0; l < LINES; l++)
            for (int k = 0; k < 4; k++)
                model_mem[l][k] = 64'd0;
        model_err = 1'b0;
    endtask

    // Called at a falling edge; returns at the falling edge inside the first IDLE cycle afterwards.
    task automatic run_txn(input string tag, input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [63:0] w0, input logic [63:0] w1,
                           input logic [63:0] w2, input logic [63:0] w3);
        logic [63:0] wb [4];
        logic [63:0] exp_rd [4];
        int          line;
        int          first;
        logic        exp_resp;
        wb[0] = w0; wb[1] = w1; wb[2] = w2; wb[3] = w3;
        line  = int'(addr / 32) % LINES;
        for (int k = 0; k < 4; k++) exp_rd[k] = rd ? model_mem[line][k] : 64'd0;
        if (rd && wr) model_err = 1'b1;
        first = 0;
        pmem_read    = rd;
        pmem_write   = wr;
        pmem_address = addr;
        @(negedge clk);
        for (int n = 1; n <= LATENCY + 5; n++) begin
            // Request lines are noise after the sample edge; quiet them for the DONE cycle.
            pmem_read    = (n <= LATENCY + 4) ? 1'($urandom_range(0, 1)) : 1'b0;
            pmem_write   = (n <= LATENCY + 4) ? 1'($urandom_range(0, 1)) : 1'b0;
            pmem_address = $urandom;
            @(negedge clk);
            exp_resp = (n >= LATENCY + 1) && (n <= LATENCY + 4);
            check($sformatf("%s_resp_e%0d", tag, n), 64'(pmem_resp), 64'(exp_resp));
            check($sformatf("%s_rdata_e%0d", tag, n), pmem_rdata,
                  exp_resp ? exp_rd[n-LATENCY-1] : 64'd0);
            if (exp_resp && first == 0) first = n;
            pmem_wdata = exp_resp ? wb[n-LATENCY-1] : {$urandom, $urandom};
        end
        check($sformatf("%s_first_resp_edge", tag), 64'(first), 64'(LATENCY + 1));
        check($sformatf("%s_proto_err", tag), 64'(proto_err), 64'(model_err));
        if (wr && !rd)
            for (int k = 0; k < 4; k++) model_mem[line][k] = wb[k];
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] ra;
        logic        rw;
        pass_cnt     = 0;
        total_cnt    = 0;
        reset_n      = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 32'd0;
        pmem_wdata   = 64'd0;
        model_clear();

        repeat (3) @(negedge clk);
        check("rst_resp", 64'(pmem_resp), 64'd0);
        check("rst_rdata", pmem_rdata, 64'd0);
        check("rst_err", 64'(proto_err), 64'd0);
        check("rst_state_idle", 64'(dbg_state), 64'd0);
        reset_n = 1'b1;

        run_txn("rd_1e0_post_rst", 1'b1, 1'b0, 32'h1E0, 0, 0, 0, 0);
        run_txn("wr_060", 1'b0, 1'b1, 32'h60, 64'h1111111111111111, 64'h2222222222222222,
                64'h3333333333333333, 64'h4444444444444444);
        run_txn("rd_060", 1'b1, 1'b0, 32'h60, 0, 0, 0, 0);
        run_txn("rd_27c_alias", 1'b1, 1'b0, 32'h27C, 0, 0, 0, 0);
        run_txn("both_060", 1'b1, 1'b1, 32'h60, 64'hDEADBEEFDEADBEEF, 64'hDEADBEEFDEADBEEF,
                64'hDEADBEEFDEADBEEF, 64'hDEADBEEFDEADBEEF);
        run_txn("rd_060_after_both", 1'b1, 1'b0, 32'h60, 0, 0, 0, 0);

        for (int t = 0; t < 12; t++) begin
            ra = $urandom;
            rw = 1'($urandom_range(0, 1));
            run_txn($sformatf("rand%0d", t), !rw, rw, ra, {$urandom, $urandom},
                    {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
        end

        // Write to 0x60 interrupted by reset after beat 1 has been committed.
        pmem_read    = 1'b0;
        pmem_write   = 1'b1;
        pmem_address = 32'h60;
        @(negedge clk);
        pmem_write = 1'b0;
        repeat (LATENCY + 1) @(negedge clk);
        pmem_wdata = 64'hAAAA0000AAAA0000;
        @(negedge clk);
        pmem_wdata = 64'hBBBB0000BBBB0000;
        @(posedge clk);
        #2;
        check("mid_burst_resp_before_rst", 64'(pmem_resp), 64'd1);
        reset_n = 1'b0;
        #1;
        check("async_rst_resp", 64'(pmem_resp), 64'd0);
        check("async_rst_rdata", pmem_rdata, 64'd0);
        check("async_rst_err", 64'(proto_err), 64'd0);
        model_clear();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        run_txn("rd_060_after_rst", 1'b1, 1'b0, 32'h60, 0, 0, 0, 0);
        run_txn("rd_rand_after_rst", 1'b1, 1'b0, $urandom, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
